// File: rtl/tile_sprite_renderer.sv
// Tile/sprite pixel renderer: scans all entity channels one tile ahead, fetches
// one sprite line per tile from a 1-cycle ROM, and emits a 1-bit colour.
`timescale 1ns/1ps
module tile_sprite_renderer #(
  parameter int   NUM_ENTITIES = 9,
  parameter int   TILE_SIZE    = 8,
  parameter int   UPSCALE      = 5,
  parameter int   H_TILES      = 16,
  parameter int   V_TILES      = 12,
  parameter int   H_ACTIVE     = 640,
  parameter int   V_TOTAL      = 525,
  parameter logic BG_COLOUR    = 1'b0,
  localparam int  LW           = $clog2(TILE_SIZE)
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [9:0]                  counter_H,
  input  logic [9:0]                  counter_V,
  input  logic [NUM_ENTITIES*18-1:0]  entities,
  input  logic [NUM_ENTITIES*2-1:0]   entity_mode,
  output logic                        rom_req,
  output logic [3:0]                  rom_sprite_id,
  output logic [1:0]                  rom_orientation,
  output logic [LW-1:0]               rom_line,
  input  logic [TILE_SIZE-1:0]        rom_data,
  output logic                        colour,
  output logic                        scan_overrun
);
  localparam int TW = TILE_SIZE * UPSCALE;

  typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_t;
  state_t state_q, state_d;

  logic [9:0] upCnt_q, subCnt_q, tileCnt_q, upCnt_d, subCnt_d, tileCnt_d;
  logic [9:0] upNow, subNow, tileNow;
  logic inActive, tileStart, colTrig, lineTrig, trig;
  logic [3:0] tColNow;

  // Counters hold the position of counter_H+1, so the live position is a mux.
  always_comb begin
    upNow     = (counter_H == '0) ? '0 : upCnt_q;
    subNow    = (counter_H == '0) ? '0 : subCnt_q;
    tileNow   = (counter_H == '0) ? '0 : tileCnt_q;
    upCnt_d   = upNow + 10'd1;
    subCnt_d  = subNow;
    tileCnt_d = tileNow;
    if (upNow == 10'(UPSCALE - 1)) begin
      upCnt_d = '0;
      if (subNow == 10'(TILE_SIZE - 1)) begin
        subCnt_d  = '0;
        tileCnt_d = tileNow + 10'd1;
      end else begin
        subCnt_d = subNow + 10'd1;
      end
    end
    inActive  = counter_H < 10'(H_ACTIVE);
    tileStart = inActive && upNow == '0 && subNow == '0;
    colTrig   = tileStart && tileNow < 10'(H_TILES - 1);
    lineTrig  = counter_H == 10'(H_ACTIVE);
    trig      = colTrig || lineTrig;
    tColNow   = lineTrig ? 4'd0 : 4'(tileNow + 10'd1);
  end

  logic [9:0] vSel, rem;
  logic [4:0] rowCnt;
  logic rowOk;
  logic [LW-1:0] sRow;

  // Tile row and sprite row by repeated conditional subtraction.
  always_comb begin
    vSel = counter_V;
    if (lineTrig) vSel = (counter_V == 10'(V_TOTAL - 1)) ? '0 : counter_V + 10'd1;
    rem    = vSel;
    rowCnt = '0;
    for (int k = 0; k < V_TILES; k++) begin
      if (rem >= 10'(TW)) begin
        rem    = rem - 10'(TW);
        rowCnt = rowCnt + 5'd1;
      end
    end
    rowOk = rem < 10'(TW);
    sRow  = '0;
    for (int k = 0; k < TILE_SIZE - 1; k++) begin
      if (rem >= 10'(UPSCALE)) begin
        rem  = rem - 10'(UPSCALE);
        sRow = sRow + LW'(1);
      end
    end
  end

  logic [4:0] idx_q, tRow_q;
  logic [3:0] tCol_q, winId_q;
  logic [1:0] winOr_q;
  logic tRowOk_q, hit_q, winFlip_q;
  logic [LW-1:0] sRow_q;
  logic [17:0] ent;
  logic [1:0] eMode;
  logic colHit, chanMatch, lastIdx;
  logic [3:0] selId;
  logic [1:0] selOr;
  logic selFlip;

  always_comb begin
    ent       = entities[int'(idx_q)*18 +: 18];
    eMode     = entity_mode[int'(idx_q)*2 +: 2];
    colHit    = (eMode == 2'b10) ?
                (tCol_q >= ent[11:8] && {1'b0, tCol_q} <= {1'b0, ent[11:8]} + {1'b0, ent[3:0]}) :
                (tCol_q == ent[11:8]);
    chanMatch = state_q == SCAN && eMode != 2'b11 && ent[17:14] != 4'hF && tRowOk_q &&
                {1'b0, ent[7:4]} == tRow_q && {1'b0, ent[11:8]} < 5'(H_TILES) && colHit;
    lastIdx   = idx_q == 5'(NUM_ENTITIES - 1);
    selId     = hit_q ? winId_q : ent[17:14];
    selOr     = hit_q ? winOr_q : ent[13:12];
    selFlip   = hit_q ? winFlip_q : (eMode == 2'b01);
  end

  // A new trigger always restarts the scan, even over an unfinished one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      SCAN:    if (lastIdx) state_d = FETCH;
      FETCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (trig) state_d = SCAN;
  end

  logic [TILE_SIZE-1:0] nextLine_q, curLine_q, nextNow, lineNow;
  logic nextValid_q, curValid_q, capPend_q, capHit_q, nextValidNow, validNow;
  logic romReq_q, colour_q, overrun_q;
  logic [3:0] romId_q;
  logic [1:0] romOr_q;
  logic [LW-1:0] romLine_q;

  // ROM data is forwarded straight to the tile boundary when capture coincides with it.
  always_comb begin
    nextNow      = capPend_q ? (capHit_q ? rom_data : '0) : nextLine_q;
    nextValidNow = capPend_q ? capHit_q : nextValid_q;
    lineNow      = tileStart ? nextNow : curLine_q;
    validNow     = tileStart ? nextValidNow : curValid_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      upCnt_q     <= '0;
      subCnt_q    <= '0;
      tileCnt_q   <= '0;
      idx_q       <= '0;
      tRow_q      <= '0;
      tCol_q      <= '0;
      tRowOk_q    <= 1'b0;
      sRow_q      <= '0;
      hit_q       <= 1'b0;
      winId_q     <= '0;
      winOr_q     <= '0;
      winFlip_q   <= 1'b0;
      nextLine_q  <= '0;
      curLine_q   <= '0;
      nextValid_q <= 1'b0;
      curValid_q  <= 1'b0;
      capPend_q   <= 1'b0;
      capHit_q    <= 1'b0;
      romReq_q    <= 1'b0;
      romId_q     <= '0;
      romOr_q     <= '0;
      romLine_q   <= '0;
      colour_q    <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      upCnt_q   <= upCnt_d;
      subCnt_q  <= subCnt_d;
      tileCnt_q <= tileCnt_d;
      romReq_q  <= 1'b0;
      if (capPend_q) begin
        nextLine_q  <= nextNow;
        nextValid_q <= nextValidNow;
        capPend_q   <= 1'b0;
      end
      if (trig) begin
        tCol_q      <= tColNow;
        tRow_q      <= rowCnt;
        tRowOk_q    <= rowOk;
        sRow_q      <= sRow;
        idx_q       <= '0;
        hit_q       <= 1'b0;
        nextValid_q <= 1'b0;
        nextLine_q  <= '0;
        if (state_q != IDLE) overrun_q <= 1'b1;
      end else if (state_q == SCAN) begin
        if (chanMatch && !hit_q) begin
          hit_q     <= 1'b1;
          winId_q   <= ent[17:14];
          winOr_q   <= ent[13:12];
          winFlip_q <= eMode == 2'b01;
        end
        idx_q <= idx_q + 5'd1;
        if (lastIdx && (hit_q || chanMatch)) begin
          romReq_q  <= 1'b1;
          romId_q   <= selId;
          romOr_q   <= selOr;
          romLine_q <= selFlip ? LW'(TILE_SIZE - 1) - sRow_q : sRow_q;
        end
      end else if (state_q == FETCH) begin
        capPend_q <= 1'b1;
        capHit_q  <= romReq_q;
      end
      if (tileStart) begin
        curLine_q  <= nextNow;
        curValid_q <= nextValidNow;
      end
      colour_q <= (inActive && validNow) ? lineNow[subNow[LW-1:0]] : BG_COLOUR;
    end
  end

  assign rom_req         = romReq_q;
  assign rom_sprite_id   = romId_q;
  assign rom_orientation = romOr_q;
  assign rom_line        = romLine_q;
  assign colour          = colour_q;
  assign scan_overrun    = overrun_q;
endmodule

// File: tb/tb_tile_sprite_renderer.sv
// Bench for tile_sprite_renderer: directed scenarios, a per-pixel reference model
// of the rendered picture, and a second instance sized to overrun its scan budget.
`timescale 1ns/1ps
module tb_tile_sprite_renderer;
  localparam int NE = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [9:0] counterH, counterV;
  logic [NE*18-1:0] entities;
  logic [NE*2-1:0] entityMode;
  logic romReq, colour, overrun;
  logic [3:0] romId;
  logic [1:0] romOr;
  logic [2:0] romLine;
  logic [7:0] romData = 8'h00;

  logic [16*18-1:0] ent2 = '0;
  logic [31:0] mode2 = '0;
  logic romReq2, colour2, overrun2;
  logic [3:0] romId2;
  logic [1:0] romOr2;
  logic [2:0] romLine2;
  logic [7:0] romData2 = 8'h00;

  int checks = 0;
  int errors = 0;

  tile_sprite_renderer dut (
    .clk_in(clk), .reset(reset), .counter_H(counterH), .counter_V(counterV),
    .entities(entities), .entity_mode(entityMode), .rom_req(romReq),
    .rom_sprite_id(romId), .rom_orientation(romOr), .rom_line(romLine),
    .rom_data(romData), .colour(colour), .scan_overrun(overrun)
  );

  tile_sprite_renderer #(.NUM_ENTITIES(16), .UPSCALE(2), .H_ACTIVE(256)) dutOvr (
    .clk_in(clk), .reset(reset), .counter_H(counterH), .counter_V(counterV),
    .entities(ent2), .entity_mode(mode2), .rom_req(romReq2),
    .rom_sprite_id(romId2), .rom_orientation(romOr2), .rom_line(romLine2),
    .rom_data(romData2), .colour(colour2), .scan_overrun(overrun2)
  );

  // Sprite ROM contents used by both the ROM model and the picture model.
  function automatic logic [7:0] romFn(input logic [3:0] id, input logic [2:0] line);
    if (id == 4'd3) return 8'h01;
    return {line, 1'b1, id};
  endfunction

  always @(posedge clk) if (romReq) romData <= romFn(romId, romLine);

  // Picture model: which sprite pixel, if any, covers screen position (h, v).
  function automatic logic expColour(input int h, input int v);
    int col, row, px, r, x, y, len, line;
    logic [1:0] m;
    logic [3:0] id;
    logic [7:0] bits;
    if (h >= 640 || v >= 480) return 1'b0;
    col = h / 40; row = v / 40; px = (h % 40) / 5; r = (v % 40) / 5;
    for (int i = 0; i < NE; i++) begin
      id = entities[i*18+14 +: 4];
      x = int'(entities[i*18+8 +: 4]);
      y = int'(entities[i*18+4 +: 4]);
      len = int'(entities[i*18 +: 4]);
      m = entityMode[i*2 +: 2];
      if (m == 2'b11 || id == 4'hF || y != row || x >= 16) continue;
      if ((m == 2'b10) ? (col >= x && col <= x + len) : (col == x)) begin
        line = (m == 2'b01) ? 7 - r : r;
        bits = romFn(id, 3'(line));
        return bits[px];
      end
    end
    return 1'b0;
  endfunction

  int reqH[$], reqV[$], reqId[$], reqLine[$], reqOr[$];
  always @(negedge clk) if (romReq) begin
    reqH.push_back(int'(counterH)); reqV.push_back(int'(counterV));
    reqId.push_back(int'(romId)); reqLine.push_back(int'(romLine)); reqOr.push_back(int'(romOr));
  end

  // Colour check against the model for the pixel presented one clock earlier.
  int hPrev = 0, vPrev = 0;
  bit prevEn = 0, modelOn = 0;
  logic lineLog [0:1023];
  always @(negedge clk) begin
    logic e;
    if (prevEn) begin
      e = expColour(hPrev, vPrev);
      checks++;
      if (colour !== e) begin
        errors++;
        $display("[TB] FAIL colour h=%0d v=%0d got %b want %b", hPrev, vPrev, colour, e);
      end
    end
    lineLog[hPrev] = colour;
    hPrev = int'(counterH); vPrev = int'(counterV);
    prevEn = modelOn && !reset;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [3:0] id, input logic [1:0] ori,
                               input logic [3:0] x, input logic [3:0] y,
                               input logic [3:0] len, input logic [1:0] mode);
    entities[ch*18 +: 18] = {id, ori, x, y, len};
    entityMode[ch*2 +: 2] = mode;
  endtask

  task automatic clearEntities();
    for (int i = 0; i < NE; i++) applyStimulus(i, 4'hF, 2'b00, 4'd0, 4'd0, 4'd0, 2'b11);
  endtask

  task automatic clearReqs();
    reqH.delete(); reqV.delete(); reqId.delete(); reqLine.delete(); reqOr.delete();
  endtask

  task automatic driveCycle(input int h, input int v);
    @(posedge clk); #1;
    counterH = 10'(h); counterV = 10'(v);
  endtask

  task automatic runRange(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) driveCycle(h, v);
  endtask

  // Warm-up runs the previous line's end so column 0 is prepared by the current config.
  task automatic runLines(input int vStart, input int n);
    modelOn = 0;
    runRange((vStart == 0) ? 524 : vStart - 1, 640, 799);
    modelOn = 1;
    for (int k = 0; k < n; k++) runRange(vStart + k, 0, 799);
    modelOn = 0;
  endtask

  function automatic int findReq(input int h);
    foreach (reqH[i]) if (reqH[i] == h) return i;
    return -1;
  endfunction

  int idx;

  initial begin
    reset = 1'b1; counterH = '0; counterV = 10'd200;
    clearEntities();
    applyStimulus(0, 4'd1, 2'b00, 4'd5, 4'd5, 4'd0, 2'b00);
    applyStimulus(4, 4'd2, 2'b00, 4'd5, 4'd5, 4'd0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_colour", int'(colour), 1);
    checkOutput("reset_rom_req", int'(romReq), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_rom_id", int'(romId), 0);

    // Release, then reset again just after the trigger for tile column 5.
    clearReqs();
    @(posedge clk); #1; reset = 1'b0; counterH = '0;
    runRange(200, 1, 161);
    @(posedge clk); #1; reset = 1'b1; counterH = 10'd162;
    driveCycle(163, 200);
    @(negedge clk);
    checkOutput("midline_reset_colour", int'(colour), 1);
    checkOutput("midline_reset_req", int'(romReq), 0);
    checkOutput("midline_reset_overrun", int'(overrun), 0);
    driveCycle(164, 200);
    @(posedge clk); #1; reset = 1'b0; counterH = 10'd165;
    runRange(200, 166, 199);
    @(negedge clk);
    checkOutput("reset_abort_no_req", reqH.size(), 0);
    checkOutput("ovr_set", int'(overrun2), 1);

    // Priority and disable.
    clearReqs(); runLines(200, 1);
    idx = findReq(170);
    checkOutput("prio_req_seen", int'(idx >= 0), 1);
    if (idx >= 0) checkOutput("prio_id", reqId[idx], 1);
    applyStimulus(0, 4'd1, 2'b00, 4'd5, 4'd5, 4'd0, 2'b11);
    clearReqs(); runLines(200, 1);
    idx = findReq(170);
    checkOutput("disable_req_seen", int'(idx >= 0), 1);
    if (idx >= 0) checkOutput("disable_id", reqId[idx], 2);
    applyStimulus(4, 4'hF, 2'b00, 4'd5, 4'd5, 4'd0, 2'b00);
    clearReqs(); runLines(200, 1);
    checkOutput("idF_no_req", reqH.size(), 0);

    // Single sprite.
    clearEntities();
    applyStimulus(0, 4'd3, 2'b00, 4'd2, 4'd1, 4'd0, 2'b00);
    checkOutput("model_pin_hit", int'(expColour(80, 40)), 1);
    checkOutput("model_pin_edge", int'(expColour(85, 40)), 0);
    runLines(40, 1);
    checkOutput("single_h79", int'(lineLog[79]), 0);
    checkOutput("single_h80", int'(lineLog[80]), 1);
    checkOutput("single_h84", int'(lineLog[84]), 1);
    checkOutput("single_h85", int'(lineLog[85]), 0);
    runLines(41, 4);

    // Vertical flip.
    clearEntities();
    applyStimulus(1, 4'd6, 2'b10, 4'd3, 4'd2, 4'd0, 2'b01);
    clearReqs(); runLines(80, 1);
    idx = findReq(90);
    checkOutput("flip_top_seen", int'(idx >= 0), 1);
    if (idx >= 0) begin
      checkOutput("flip_top_line", reqLine[idx], 7);
      checkOutput("flip_orient", reqOr[idx], 2);
    end
    clearReqs(); runLines(115, 1);
    idx = findReq(90);
    checkOutput("flip_bottom_seen", int'(idx >= 0), 1);
    if (idx >= 0) checkOutput("flip_bottom_line", reqLine[idx], 0);

    // Array clipped at the right edge.
    clearEntities();
    applyStimulus(2, 4'd7, 2'b00, 4'd13, 4'd0, 4'd5, 2'b10);
    checkOutput("model_pin_array", int'(expColour(520, 1)), 1);
    clearReqs(); runLines(0, 2);
    checkOutput("array_req_count", reqH.size(), 6);
    checkOutput("array_col13", int'(findReq(490) >= 0), 1);
    checkOutput("array_col14", int'(findReq(530) >= 0), 1);
    checkOutput("array_col15", int'(findReq(570) >= 0), 1);
    checkOutput("array_col0_blank", int'(lineLog[10]), 0);
    checkOutput("array_h520", int'(lineLog[520]), 1);

    // Frame wrap at the last line end.
    clearEntities();
    applyStimulus(3, 4'd5, 2'b00, 4'd0, 4'd0, 4'd0, 2'b00);
    clearReqs(); runLines(0, 1);
    idx = findReq(650);
    checkOutput("wrap_req_seen", int'(idx >= 0), 1);
    if (idx >= 0) begin
      checkOutput("wrap_req_v", reqV[idx], 524);
      checkOutput("wrap_req_id", reqId[idx], 5);
      checkOutput("wrap_req_line", reqLine[idx], 0);
    end
    checkOutput("wrap_h2", int'(lineLog[2]), 1);

    checkOutput("main_no_overrun", int'(overrun), 0);
    checkOutput("ovr_sticky", int'(overrun2), 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ovr_cleared", int'(overrun2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
